// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier with valid/ready handshakes on both sides.
// One multiplier bit is consumed per RUN cycle, LSB first; signed mode subtracts the MSB partial product.
module mul_seq #(
  parameter int N_BIT    = 4,
  parameter int RES_SIZE = 2 * N_BIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_BIT-1:0]    A,
  input  logic [N_BIT-1:0]    B,
  input  logic                mul_type,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RES_SIZE-1:0] product,
  output logic                busy
);

  localparam int ACC_W = RES_SIZE + 1;
  localparam int CNT_W = $clog2(N_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BIT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_d;
  logic [ACC_W-1:0]    mcand_q;
  logic [N_BIT-1:0]    mplier_q;
  logic                sgn_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                out_valid_q;
  logic                busy_q;
  logic [RES_SIZE-1:0] product_q;

  // mcand_q is pre-shifted each step, so it is already aligned at bit k
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      if (sgn_q && (cnt_q == LAST)) acc_d = acc_q - mcand_q;
      else                          acc_d = acc_q + mcand_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      sgn_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      product_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q  <= mul_type ? {{(ACC_W-N_BIT){A[N_BIT-1]}}, A}
                                 : {{(ACC_W-N_BIT){1'b0}}, A};
            mplier_q <= B;
            sgn_q    <= mul_type;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            product_q   <= acc_d[RES_SIZE-1:0];
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;

endmodule
